csr_edge_fetcher: RTL and testbench
===================================

CSR_EDGE_FETCHER -- requirements
Module: csr_edge_fetcher

Interface
REQ-001 Parameters (name, default, meaning): PROC_BITS, 4, processor-tag width; PROC_ID, 0, tag placed in address bits [31+PROC_BITS:32]; LATENCY, 2, graph-memory read latency in cycles; FIFO_DEPTH, 8, output buffer entries (power of 2, at least 4).
REQ-002 Ports (name, direction, width, meaning), one clock and synchronous active-high reset:
- clk_in  in  1  sole clock
- rst_in  in  1  synchronous active-high reset
- req_valid  in  1  vertex request valid
- req_vertex  in  32  vertex id
- req_ready  out  1  request accepted when valid and ready are both high
- idx_addr  out  32+PROC_BITS  row-pointer read address
- idx_validin  out  1  row-pointer read strobe
- rowidx_in  in  32  row-pointer read data
- data_addra, data_addrb  out  32+PROC_BITS  edge read addresses, ports A and B
- data_validina, data_validinb  out  1  edge read strobes
- data_ina, data_inb  in  32  edge read data
- nbr_valid  out  1  neighbor beat valid
- nbr_data  out  32  neighbor vertex id
- nbr_last  out  1  final beat of the current request
- nbr_ready  in  1  consumer accepts the beat
- done  out  1  one-cycle pulse when the request is complete
- busy  out  1  high in every state except IDLE

Function
REQ-003 The block shall ignore any memory-side valid outputs: read data shall be sampled exactly LATENCY cycles after the cycle its strobe is high, tracked by an internal strobe shift register.
REQ-004 Every issued address shall be {PROC_ID, 32-bit index}; all 32-bit index arithmetic shall wrap modulo 2^32.
REQ-005 The state machine shall have states IDLE, IDX, WAIT, STREAM and DRAIN; req_ready shall equal (state==IDLE).
REQ-006 IDLE: on acceptance the block shall latch v=req_vertex and go to IDX.
REQ-007 IDX: the block shall issue reads of v and v+1 on consecutive cycles with idx_validin high for exactly those two cycles, then go to WAIT.
REQ-008 WAIT: the block shall capture start=rowidx at v and end=rowidx at v+1; if end<=start (unsigned) it shall go to DRAIN, otherwise it shall set ptr=start and go to STREAM.
REQ-009 STREAM: per cycle, when remaining (end-ptr) is at least 2 and credits (FIFO_DEPTH - occupancy - in-flight) are at least 2, it shall issue A=ptr and B=ptr+1 with both strobes high and advance ptr by 2.
REQ-010 STREAM: when remaining is 1 and credits are at least 1, it shall issue port A only, with data_validinb low; otherwise it shall issue nothing that cycle.
REQ-011 STREAM: after the last issue the block shall go to DRAIN.
REQ-012 Returned data shall be written to the FIFO in issue order, port A before port B in the same cycle (up to 2 writes per cycle), with a last tag set on the entry for index end-1.
REQ-013 The FIFO shall never overflow; the credit rule guarantees this.
REQ-014 Output: nbr_valid shall equal FIFO not empty, and nbr_data and nbr_last shall come from the FIFO head; an entry shall pop only when nbr_valid and nbr_ready are both high. Simultaneous push and pop shall both take effect.
REQ-015 DRAIN: when no reads are in flight and the FIFO is empty, the block shall pulse done for one cycle and return to IDLE; for an empty list, done shall assert with no nbr_valid and no data strobes.
REQ-016 Request-to-first-idx_validin latency shall be 1 cycle; with nbr_ready held high and a list of 2 or more entries, first nbr_valid shall occur at or before 2*LATENCY+4 cycles after acceptance.

Reset
REQ-017 While rst_in is high, every output shall be 0 (addresses, strobes, nbr_*, done, busy, req_ready), the FIFO and in-flight shift register shall be cleared, and state shall be IDLE.
REQ-018 Reset mid-operation shall discard all in-flight returns; the cycle after rst_in falls, req_ready shall be 1.

Verification
REQ-019 rowidx[5]=10, rowidx[6]=13, data[10..12]=7,8,9, request 5, nbr_ready=1 -> beats 7,8,9 with nbr_last only on 9, one done pulse, busy low afterward.
REQ-020 rowidx[3]=rowidx[4]=20, request 3 -> no nbr_valid, no data strobes, done pulse.
REQ-021 12-entry list, nbr_ready=0 for 30 cycles then 1 -> occupancy never exceeds FIFO_DEPTH, strobes stall, all 12 beats delivered in order.
REQ-022 5-entry list -> issues (A,B), (A,B), (A only); data_validinb low on the third issue.
REQ-023 rst_in pulsed during STREAM of a 12-entry list -> all outputs 0 during reset; the next request for a 3-entry list returns exactly 3 correct beats.
REQ-024 req_valid held high with vertex 5, then vertex 7 -> second request accepted only in the cycle after done; req_ready low throughout the first request.

Source files
------------

// File: rtl/csr_edge_fetcher.sv
// CSR neighbor fetcher: reads row pointers for a vertex, then streams its edge list through a 2-write FIFO.
// First idx strobe 1 cycle after accept; edge reads stall on FIFO credits, so nbr_ready backpressure never overflows.
module csr_edge_fetcher #(
    parameter int PROC_BITS  = 4,
    parameter int PROC_ID    = 0,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid,
    input  logic [31:0]           req_vertex,
    output logic                  req_ready,
    output logic [31+PROC_BITS:0] idx_addr,
    output logic                  idx_validin,
    input  logic [31:0]           rowidx_in,
    output logic [31+PROC_BITS:0] data_addra,
    output logic [31+PROC_BITS:0] data_addrb,
    output logic                  data_validina,
    output logic                  data_validinb,
    input  logic [31:0]           data_ina,
    input  logic [31:0]           data_inb,
    output logic                  nbr_valid,
    output logic [31:0]           nbr_data,
    output logic                  nbr_last,
    input  logic                  nbr_ready,
    output logic                  done,
    output logic                  busy
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = 16;
    localparam logic [PROC_BITS-1:0] TAG = PROC_BITS'(PROC_ID);

    typedef enum logic [2:0] {IDLE, IDX, WAIT, STREAM, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       v_q, v_d;
    logic              sel_q, sel_d;
    logic [31:0]       start_q, start_d;
    logic [31:0]       end_q, end_d;
    logic [31:0]       ptr_q, ptr_d;

    logic [LATENCY-1:0] isr_vld_q, isr_sel_q;
    logic [LATENCY-1:0] dsr_a_q, dsr_b_q, dsr_al_q, dsr_bl_q;

    logic [31:0]          mem_dat_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;
    logic [AW-1:0]        wr_q, rd_q;
    logic [CNTW-1:0]      cnt_q;

    logic          run;
    logic          idx_ret, idx_ret_end, a_ret, b_ret, pop;
    logic [CW-1:0] inflight, credit;
    logic [31:0]   rem;
    logic          idx_vld, iss_a, iss_b, last_a, last_b, done_c;
    logic [AW-1:0] wr_b;

    assign run         = ~rst_in;
    assign idx_ret     = isr_vld_q[LATENCY-1];
    assign idx_ret_end = isr_sel_q[LATENCY-1];
    assign a_ret       = dsr_a_q[LATENCY-1];
    assign b_ret       = dsr_b_q[LATENCY-1];
    assign rem         = end_q - ptr_q;
    assign wr_b        = wr_q + AW'(a_ret);

    // Credits count both buffered entries and reads still in the memory pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(dsr_a_q[i]) + CW'(dsr_b_q[i]);
        end
        credit = CW'(FIFO_DEPTH) - CW'(cnt_q) - inflight;
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        sel_d   = sel_q;
        start_d = (idx_ret && !idx_ret_end) ? rowidx_in : start_q;
        end_d   = end_q;
        ptr_d   = ptr_q;
        idx_vld = 1'b0;
        iss_a   = 1'b0;
        iss_b   = 1'b0;
        last_a  = 1'b0;
        last_b  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    v_d     = req_vertex;
                    sel_d   = 1'b0;
                    state_d = IDX;
                end
            end
            IDX: begin
                idx_vld = 1'b1;
                sel_d   = 1'b1;
                if (sel_q) state_d = WAIT;
            end
            WAIT: begin
                if (idx_ret && idx_ret_end) begin
                    end_d = rowidx_in;
                    if (rowidx_in <= start_q) begin
                        state_d = DRAIN;
                    end else begin
                        ptr_d   = start_q;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (rem >= 32'd2 && credit >= CW'(2)) begin
                    iss_a  = 1'b1;
                    iss_b  = 1'b1;
                    last_b = (rem == 32'd2);
                    ptr_d  = ptr_q + 32'd2;
                    if (rem == 32'd2) state_d = DRAIN;
                end else if (rem == 32'd1 && credit >= CW'(1)) begin
                    iss_a   = 1'b1;
                    last_a  = 1'b1;
                    ptr_d   = ptr_q + 32'd1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready     = run && (state_q == IDLE);
    assign busy          = run && (state_q != IDLE);
    assign done          = run && done_c;
    assign idx_validin   = run && idx_vld;
    assign data_validina = run && iss_a;
    assign data_validinb = run && iss_b;
    assign idx_addr      = idx_validin   ? {TAG, v_q + {31'd0, sel_q}} : '0;
    assign data_addra    = data_validina ? {TAG, ptr_q} : '0;
    assign data_addrb    = data_validinb ? {TAG, ptr_q + 32'd1} : '0;
    assign nbr_valid     = run && (cnt_q != '0);
    assign nbr_data      = nbr_valid ? mem_dat_q[rd_q] : '0;
    assign nbr_last      = nbr_valid && mem_last_q[rd_q];
    assign pop           = nbr_valid && nbr_ready;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            v_q       <= '0;
            sel_q     <= 1'b0;
            start_q   <= '0;
            end_q     <= '0;
            ptr_q     <= '0;
            isr_vld_q <= '0;
            isr_sel_q <= '0;
            dsr_a_q   <= '0;
            dsr_b_q   <= '0;
            dsr_al_q  <= '0;
            dsr_bl_q  <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            end_q     <= end_d;
            ptr_q     <= ptr_d;
            isr_vld_q <= (isr_vld_q << 1) | LATENCY'(idx_validin);
            isr_sel_q <= (isr_sel_q << 1) | LATENCY'(sel_q);
            dsr_a_q   <= (dsr_a_q << 1) | LATENCY'(data_validina);
            dsr_b_q   <= (dsr_b_q << 1) | LATENCY'(data_validinb);
            dsr_al_q  <= (dsr_al_q << 1) | LATENCY'(last_a);
            dsr_bl_q  <= (dsr_bl_q << 1) | LATENCY'(last_b);
            wr_q      <= wr_q + AW'(a_ret) + AW'(b_ret);
            rd_q      <= rd_q + AW'(pop);
            cnt_q     <= cnt_q + CNTW'(a_ret) + CNTW'(b_ret) - CNTW'(pop);
        end
    end

    // Port A lands ahead of port B so same-cycle returns keep issue order.
    always_ff @(posedge clk_in) begin
        if (run && a_ret) begin
            mem_dat_q[wr_q]  <= data_ina;
            mem_last_q[wr_q] <= dsr_al_q[LATENCY-1];
        end
        if (run && b_ret) begin
            mem_dat_q[wr_b]  <= data_inb;
            mem_last_q[wr_b] <= dsr_bl_q[LATENCY-1];
        end
    end
endmodule

// File: tb/tb_csr_edge_fetcher.sv
// Bench for csr_edge_fetcher: latency-exact memory model, vector table and scoreboard of expected beats.
module tb_csr_edge_fetcher;
    localparam int PB    = 4;
    localparam int PID   = 5;
    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int AWID  = 32 + PB;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            req_valid;
    logic [31:0]     req_vertex;
    logic            req_ready;
    logic [AWID-1:0] idx_addr, data_addra, data_addrb;
    logic            idx_validin, data_validina, data_validinb;
    logic [31:0]     rowidx_in, data_ina, data_inb;
    logic            nbr_valid, nbr_last, nbr_ready, done, busy;
    logic [31:0]     nbr_data;

    csr_edge_fetcher #(.PROC_BITS(PB), .PROC_ID(PID), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_vertex(req_vertex),
        .req_ready(req_ready), .idx_addr(idx_addr), .idx_validin(idx_validin), .rowidx_in(rowidx_in),
        .data_addra(data_addra), .data_addrb(data_addrb), .data_validina(data_validina),
        .data_validinb(data_validinb), .data_ina(data_ina), .data_inb(data_inb),
        .nbr_valid(nbr_valid), .nbr_data(nbr_data), .nbr_last(nbr_last), .nbr_ready(nbr_ready),
        .done(done), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic            iv;
        logic [AWID-1:0] ia;
        logic            av;
        logic [AWID-1:0] aa;
        logic            bv;
        logic [AWID-1:0] ba;
    } mreq_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] v;
        logic [31:0] rs;
        logic [31:0] re;
        int          stall;
        int          na;
        int          nb;
        int          fill;
    } vec_t;

    logic [31:0] rowmem  [logic [31:0]];
    logic [31:0] datamem [logic [31:0]];
    mreq_t       hist [LAT+1];
    beat_t       exp_q [$];
    vec_t        vecs [8];

    int errors = 0;
    int checks = 0;
    int a_cnt, b_cnt, done_cnt, proto_err, max_out;
    int issued, popped;

    function automatic logic [31:0] row_rd(input logic [31:0] i);
        if (rowmem.exists(i)) return rowmem[i];
        return 32'hBAD0_0000 ^ i;
    endfunction

    function automatic logic [31:0] data_rd(input logic [31:0] i);
        if (datamem.exists(i)) return datamem[i];
        return i * 32'd7 + 32'd3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] rs, input logic [31:0] re);
        logic [31:0] i;
        if (re > rs) begin
            i = rs;
            while (i != re) begin
                exp_q.push_back('{dat: data_rd(i), last: (i == re - 32'd1)});
                i++;
            end
        end
    endtask

    // Memory model answers exactly LAT cycles after each strobe, junk otherwise; monitor scores beats.
    always @(negedge clk_in) begin
        beat_t e;
        for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{iv: idx_validin, ia: idx_addr, av: data_validina, aa: data_addra,
                    bv: data_validinb, ba: data_addrb};
        rowidx_in = hist[LAT].iv ? row_rd(hist[LAT].ia[31:0]) : $urandom;
        data_ina  = hist[LAT].av ? data_rd(hist[LAT].aa[31:0]) : $urandom;
        data_inb  = hist[LAT].bv ? data_rd(hist[LAT].ba[31:0]) : $urandom;
        if (rst_in) begin
            issued = 0;
            popped = 0;
        end else begin
            if (idx_validin && idx_addr[AWID-1:32] != PB'(PID)) proto_err++;
            if (data_validina && data_addra[AWID-1:32] != PB'(PID)) proto_err++;
            if (data_validinb && data_addrb[AWID-1:32] != PB'(PID)) proto_err++;
            if (data_validinb && !data_validina) proto_err++;
            if (data_validina) a_cnt++;
            if (data_validinb) b_cnt++;
            issued += int'(data_validina) + int'(data_validinb);
            if (issued - popped > max_out) max_out = issued - popped;
            if (nbr_valid && nbr_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat: got %0h expected none", nbr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat data", nbr_data, e.dat);
                    chk("beat last", nbr_last, e.last);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk(name, |{req_ready, idx_addr, idx_validin, data_addra, data_addrb, data_validina,
                    data_validinb, nbr_valid, nbr_data, nbr_last, done, busy}, 0);
    endtask

    task automatic run_vec(input vec_t t);
        int n, first_nv;
        bit got_done;
        a_cnt = 0; b_cnt = 0; done_cnt = 0; proto_err = 0; max_out = 0;
        push_exp(t.rs, t.re);
        nbr_ready  = (t.stall == 0);
        req_valid  = 1'b1;
        req_vertex = t.v;
        n = 0; first_nv = -1; got_done = 1'b0;
        while (!got_done && n < 400) begin
            @(posedge clk_in); #1;
            n++;
            if (n == 1) begin
                req_valid  = 1'b0;
                req_vertex = '0;
            end
            if (t.stall != 0 && n == t.stall) begin
                chk("stall fill", a_cnt + b_cnt, t.fill);
                nbr_ready = 1'b1;
            end
            @(negedge clk_in);
            if (n == 1) chk("first idx strobe", idx_validin, 1);
            if (nbr_valid && first_nv < 0) first_nv = n;
            got_done = done;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done timeout: vertex %0h got no done expected done", t.v);
        end
        @(negedge clk_in);
        chk("busy after done", busy, 0);
        chk("ready after done", req_ready, 1);
        @(posedge clk_in); #1;
        chk("done pulses", done_cnt, 1);
        chk("beats left", exp_q.size(), 0);
        chk("port A issues", a_cnt, t.na);
        chk("port B issues", b_cnt, t.nb);
        chk("protocol errors", proto_err, 0);
        chk("no overflow", max_out <= DEPTH, 1);
        if (t.na + t.nb == 0) chk("no nbr_valid", first_nv, -1);
        if (t.stall == 0 && t.na + t.nb >= 2)
            chk("first beat latency", (first_nv >= 1) && (first_nv <= 2 * LAT + 4), 1);
        exp_q.delete();
    endtask

    initial begin
        int n, ready_err;
        bit got_done;
        vecs[0] = '{32'd5,          32'd10,          32'd13,  0,  2, 1, 0};
        vecs[1] = '{32'd3,          32'd20,          32'd20,  0,  0, 0, 0};
        vecs[2] = '{32'd8,          32'd40,          32'd52,  30, 6, 6, DEPTH};
        vecs[3] = '{32'd11,         32'd60,          32'd65,  0,  3, 2, 0};
        vecs[4] = '{32'd14,         32'd30,          32'd25,  0,  0, 0, 0};
        vecs[5] = '{32'd17,         32'd100,         32'd101, 0,  1, 0, 0};
        vecs[6] = '{32'hFFFF_FFFF,  32'd200,         32'd203, 0,  2, 1, 0};
        vecs[7] = '{32'd23,         32'hFFFF_FFFE,   32'd2,   0,  0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            rowmem[vecs[k].v]         = vecs[k].rs;
            rowmem[vecs[k].v + 32'd1] = vecs[k].re;
        end
        rowmem[32'd7]  = 32'd37;
        datamem[32'd10] = 32'd7;
        datamem[32'd11] = 32'd8;
        datamem[32'd12] = 32'd9;
        for (int i = 0; i <= LAT; i++) hist[i] = '0;

        rst_in = 1'b1; req_valid = 1'b0; req_vertex = '0; nbr_ready = 1'b0;
        rowidx_in = '0; data_ina = '0; data_inb = '0;
        a_cnt = 0; b_cnt = 0; done_cnt = 0; proto_err = 0; max_out = 0; issued = 0; popped = 0;
        repeat (2) begin
            @(negedge clk_in);
            chk_reset_outputs("outputs in reset");
        end
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready after reset", req_ready, 1);

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset in the middle of a stalled stream, then a short list must come back clean.
        nbr_ready = 1'b0; req_valid = 1'b1; req_vertex = 32'd8;
        @(posedge clk_in); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("busy before reset", busy, 1);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            chk_reset_outputs("outputs in mid reset");
        end
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        exp_q.delete();
        @(negedge clk_in);
        chk("ready after mid reset", req_ready, 1);
        run_vec(vecs[0]);

        // Back-to-back requests with req_valid never dropping.
        done_cnt = 0;
        push_exp(32'd10, 32'd13);
        push_exp(32'd37, 32'd40);
        nbr_ready = 1'b1; req_valid = 1'b1; req_vertex = 32'd5;
        @(posedge clk_in); #1;
        req_vertex = 32'd7;
        ready_err = 0; n = 0; got_done = 1'b0;
        while (!got_done && n < 200) begin
            @(negedge clk_in);
            n++;
            got_done = done;
            if (!got_done && req_ready) ready_err++;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL first done timeout: got no done expected done");
        end
        chk("ready low during first", ready_err, 0);
        chk("ready at done", req_ready, 0);
        @(negedge clk_in);
        chk("ready cycle after done", req_ready, 1);
        @(posedge clk_in); #1;
        req_valid = 1'b0;
        n = 0; got_done = 1'b0;
        while (!got_done && n < 200) begin
            @(negedge clk_in);
            n++;
            got_done = done;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL second done timeout: got no done expected done");
        end
        @(posedge clk_in); #1;
        chk("back-to-back done pulses", done_cnt, 2);
        chk("back-to-back beats left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
